// File: rtl/l1_line_fill_bridge.sv
// Line-fill bridge: takes one cache-line read request and issues it as single-word
// pipelined memory reads, forwarding the returned words as registered rsp beats.
module l1_line_fill_bridge #(
   parameter int LINE_W          = 8,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_request,
   input  logic [31:0] req_addr,
   input  logic [4:0]  req_size,
   input  logic        req_rnw,
   output logic        req_ack,
   output logic [31:0] rsp_data,
   output logic        rsp_data_valid,
   output logic        mem_rd_request,
   output logic [31:0] mem_rd_addr,
   input  logic        mem_rd_ack,
   input  logic [31:0] mem_rd_data,
   input  logic        mem_rd_data_valid,
   output logic        busy
);

   localparam int OFF = 2 + $clog2(LINE_W);
   localparam int OW  = $clog2(MAX_OUTSTANDING) + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t         state_reg, state_next;
   logic [31:0]    base_reg;
   logic [5:0]     total_reg;
   logic [5:0]     issue_cnt_reg;
   logic [5:0]     ret_cnt_reg;
   logic [OW-1:0]  outstanding_reg, outstanding_next;
   logic [31:0]    rsp_data_reg;
   logic           rsp_data_valid_reg;

   logic           can_issue;
   logic           ack_accept;
   logic           data_accept;
   logic           last_issue;
   logic           last_ret;
   logic           unused_addr_bits;

   assign unused_addr_bits = ^req_addr[OFF-1:0];

   assign can_issue   = (state_reg == ST_ISSUE) && (outstanding_reg < OW'(MAX_OUTSTANDING));
   assign ack_accept  = mem_rd_ack && can_issue;
   // Data arriving while idle belongs to an aborted fill and is dropped.
   assign data_accept = mem_rd_data_valid && (state_reg != ST_IDLE);
   assign last_issue  = (issue_cnt_reg == total_reg - 6'd1);
   assign last_ret    = (ret_cnt_reg == total_reg - 6'd1);

   assign mem_rd_request = can_issue;
   assign mem_rd_addr    = base_reg + {24'd0, issue_cnt_reg, 2'b00};
   assign rsp_data       = rsp_data_reg;
   assign rsp_data_valid = rsp_data_valid_reg;
   assign busy           = (state_reg != ST_IDLE);

   always_comb begin
      state_next = state_reg;
      req_ack    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            // Hold off the next request while the previous fill's final beat is on rsp.
            req_ack = req_request && req_rnw && !rsp_data_valid_reg;
            if (req_ack)
               state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (ack_accept && last_issue)
               state_next = (data_accept && last_ret) ? ST_IDLE : ST_DRAIN;
         end
         ST_DRAIN: begin
            if (data_accept && last_ret)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      outstanding_next = outstanding_reg;
      case ({ack_accept, data_accept})
         2'b10:   outstanding_next = outstanding_reg + OW'(1);
         2'b01:   outstanding_next = outstanding_reg - OW'(1);
         default: outstanding_next = outstanding_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg          <= ST_IDLE;
         base_reg           <= '0;
         total_reg          <= '0;
         issue_cnt_reg      <= '0;
         ret_cnt_reg        <= '0;
         outstanding_reg    <= '0;
         rsp_data_reg       <= '0;
         rsp_data_valid_reg <= 1'b0;
      end else begin
         state_reg          <= state_next;
         outstanding_reg    <= outstanding_next;
         rsp_data_valid_reg <= data_accept;
         if (data_accept)
            rsp_data_reg <= mem_rd_data;
         if (req_ack) begin
            base_reg      <= {req_addr[31:OFF], {OFF{1'b0}}};
            total_reg     <= {1'b0, req_size} + 6'd1;
            issue_cnt_reg <= '0;
            ret_cnt_reg   <= '0;
         end else begin
            if (ack_accept)
               issue_cnt_reg <= issue_cnt_reg + 6'd1;
            if (data_accept)
               ret_cnt_reg <= ret_cnt_reg + 6'd1;
         end
      end
   end

`ifndef SYNTHESIS
   a_write_ignored: assert property (@(posedge clk) disable iff (rst)
      (state_reg == ST_IDLE && req_request) |-> req_rnw)
      else $warning("l1_line_fill_bridge: write request is never accepted");

   a_ack_without_req: assert property (@(posedge clk) disable iff (rst)
      mem_rd_ack |-> mem_rd_request)
      else $error("l1_line_fill_bridge: mem_rd_ack without mem_rd_request");

   a_data_before_ack: assert property (@(posedge clk) disable iff (rst)
      data_accept |-> (outstanding_reg != '0 || ack_accept))
      else $error("l1_line_fill_bridge: read data with nothing outstanding");
`endif

endmodule

// File: tb/tb_l1_line_fill_bridge.sv
// Directed bench for l1_line_fill_bridge: a small memory model with configurable
// latency/backpressure, an event log sampled on the falling edge, and checks per test.
module tb_l1_line_fill_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_request;
   logic [31:0] req_addr;
   logic [4:0]  req_size;
   logic        req_rnw;
   logic        req_ack;
   logic [31:0] rsp_data;
   logic        rsp_data_valid;
   logic        mem_rd_request;
   logic [31:0] mem_rd_addr;
   logic        mem_rd_ack;
   logic [31:0] mem_rd_data;
   logic        mem_rd_data_valid;
   logic        busy;

   always #5 clk = ~clk;

   l1_line_fill_bridge #(.LINE_W(8), .MAX_OUTSTANDING(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .req_request       (req_request),
      .req_addr          (req_addr),
      .req_size          (req_size),
      .req_rnw           (req_rnw),
      .req_ack           (req_ack),
      .rsp_data          (rsp_data),
      .rsp_data_valid    (rsp_data_valid),
      .mem_rd_request    (mem_rd_request),
      .mem_rd_addr       (mem_rd_addr),
      .mem_rd_ack        (mem_rd_ack),
      .mem_rd_data       (mem_rd_data),
      .mem_rd_data_valid (mem_rd_data_valid),
      .busy              (busy)
   );

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return a ^ 32'hC3A5_0F00;
   endfunction

   // Memory model: in-order address FIFO for 1-cycle latency, or same-cycle data.
   logic        ack_en, data_en, zero_lat, inj_valid;
   logic [31:0] fifo [0:63];
   int          wp = 0;
   int          rp = 0;
   logic        q_ne;

   assign q_ne              = (wp != rp);
   assign mem_rd_ack        = ack_en && mem_rd_request;
   assign mem_rd_data_valid = zero_lat ? mem_rd_ack : (inj_valid || (data_en && q_ne));
   assign mem_rd_data       = zero_lat ? mem_f(mem_rd_addr) :
                              (inj_valid ? 32'hDEAD_BEEF : mem_f(fifo[rp[5:0]]));

   always @(posedge clk) begin
      if (rst) begin
         wp <= 0;
         rp <= 0;
      end else begin
         if (mem_rd_ack && !zero_lat) begin
            fifo[wp[5:0]] <= mem_rd_addr;
            wp <= wp + 1;
         end
         if (!zero_lat && !inj_valid && data_en && q_ne)
            rp <= rp + 1;
      end
   end

   // Event log, sampled mid-cycle.
   int          cyc = 0;
   logic [31:0] ack_addr [0:255];
   int          ack_cyc  [0:255];
   int          n_ack = 0;
   logic [31:0] rsp_dat  [0:255];
   int          rsp_cyc  [0:255];
   logic        rsp_busy [0:255];
   int          n_rsp = 0;
   int          rack_cyc [0:63];
   int          n_rack = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_rd_request && mem_rd_ack && n_ack < 256) begin
            ack_addr[n_ack] <= mem_rd_addr;
            ack_cyc[n_ack]  <= cyc;
            n_ack           <= n_ack + 1;
         end
         if (rsp_data_valid && n_rsp < 256) begin
            rsp_dat[n_rsp]  <= rsp_data;
            rsp_cyc[n_rsp]  <= cyc;
            rsp_busy[n_rsp] <= busy;
            n_rsp           <= n_rsp + 1;
         end
         if (req_ack && n_rack < 64) begin
            rack_cyc[n_rack] <= cyc;
            n_rack           <= n_rack + 1;
         end
      end
   end

   int err_cnt = 0;
   int chk_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input string tag);
      int k = 0;
      @(negedge clk);
      while (!req_ack && k < 100) begin
         @(negedge clk);
         k++;
      end
      check(tag, {31'd0, req_ack}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input int target, input string tag);
      int k = 0;
      while (n_rsp < target && k < 200) begin
         @(posedge clk);
         k++;
      end
      #1;
      check(tag, {31'd0, (n_rsp >= target)}, 32'd1);
   endtask

   task automatic check_fill(input int ab, input int rb, input logic [31:0] a0, input string tag);
      logic [31:0] ea;
      for (int i = 0; i < 8; i++) begin
         ea = a0 + 32'(4 * i);
         check($sformatf("%s_addr%0d", tag, i), ack_addr[ab + i], ea);
         check($sformatf("%s_data%0d", tag, i), rsp_dat[rb + i], mem_f(ea));
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, r0, r1, k0;
      rst = 1'b1; req_request = 1'b0; req_addr = '0; req_size = 5'd7; req_rnw = 1'b1;
      ack_en = 1'b1; data_en = 1'b1; zero_lat = 1'b0; inj_valid = 1'b0;
      step(3);
      check("rst_req_ack", {31'd0, req_ack}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_data_valid}, 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_mem_req", {31'd0, mem_rd_request}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      step(1);

      // 1: unaligned miss address, 1-cycle memory
      a0 = n_ack; r0 = n_rsp;
      req_request = 1'b1; req_addr = 32'h1000_0014; req_size = 5'd7;
      wait_ack("t1_ack");
      req_request = 1'b0;
      check("t1_busy", {31'd0, busy}, 32'd1);
      wait_rsp(r0 + 8, "t1_rsp_done");
      step(2);
      check_fill(a0, r0, 32'h1000_0000, "t1");
      check("t1_n_ack", n_ack - a0, 32'd8);
      check("t1_busy_first", {31'd0, rsp_busy[r0]}, 32'd1);
      check("t1_busy_last", {31'd0, rsp_busy[r0 + 7]}, 32'd0);
      check("t1_rsp_hold", rsp_data, mem_f(32'h1000_001C));

      // 2: memory withholds data; outstanding limit
      data_en = 1'b0;
      a0 = n_ack; r0 = n_rsp;
      req_request = 1'b1; req_addr = 32'h2000_0000;
      wait_ack("t2_ack");
      req_request = 1'b0;
      step(12);
      check("t2_n_ack_limit", n_ack - a0, 32'd4);
      check("t2_req_stalled", {31'd0, mem_rd_request}, 32'd0);
      data_en = 1'b1;
      #1;
      check("t2_req_still_low", {31'd0, mem_rd_request}, 32'd0);
      step(1);
      check("t2_req_resume", {31'd0, mem_rd_request}, 32'd1);
      wait_rsp(r0 + 8, "t2_rsp_done");
      step(2);
      check_fill(a0, r0, 32'h2000_0000, "t2");

      // 3: zero-latency memory
      zero_lat = 1'b1;
      a0 = n_ack; r0 = n_rsp;
      req_request = 1'b1; req_addr = 32'h3000_0040;
      wait_ack("t3_ack");
      req_request = 1'b0;
      wait_rsp(r0 + 8, "t3_rsp_done");
      step(2);
      check_fill(a0, r0, 32'h3000_0040, "t3");
      for (int i = 0; i < 8; i++)
         check($sformatf("t3_lat%0d", i), rsp_cyc[r0 + i] - ack_cyc[a0 + i], 32'd1);
      check("t3_contiguous", rsp_cyc[r0 + 7] - rsp_cyc[r0], 32'd7);
      zero_lat = 1'b0;

      // 4: reset mid-fill, stale data afterwards
      a0 = n_ack; r0 = n_rsp;
      req_request = 1'b1; req_addr = 32'h4000_0000;
      wait_ack("t4_ack");
      req_request = 1'b0;
      wait_rsp(r0 + 3, "t4_three");
      rst = 1'b1; ack_en = 1'b0;
      step(2);
      check("t4_rst_busy", {31'd0, busy}, 32'd0);
      check("t4_rst_rsp_data", rsp_data, 32'd0);
      rst = 1'b0; inj_valid = 1'b1;
      r1 = n_rsp;
      step(5);
      inj_valid = 1'b0;
      step(1);
      check("t4_no_rsp", n_rsp - r1, 32'd0);
      check("t4_idle", {31'd0, busy}, 32'd0);
      check("t4_no_mem_req", {31'd0, mem_rd_request}, 32'd0);
      ack_en = 1'b1;
      a0 = n_ack; r0 = n_rsp;
      req_request = 1'b1; req_addr = 32'h5000_0008;
      #1;
      check("t4_ack_same_cycle", {31'd0, req_ack}, 32'd1);
      step(1);
      req_request = 1'b0;
      wait_rsp(r0 + 8, "t4_rsp_done");
      step(2);
      check_fill(a0, r0, 32'h5000_0000, "t4");

      // 5: back-to-back requests
      a0 = n_ack; r0 = n_rsp;
      req_request = 1'b1; req_addr = 32'h0000_0000;
      wait_ack("t5_ack1");
      req_addr = 32'h0000_0020;
      wait_ack("t5_ack2");
      req_request = 1'b0;
      check("t5_ack_gap", rack_cyc[n_rack - 1] - rsp_cyc[r0 + 7], 32'd1);
      wait_rsp(r0 + 16, "t5_rsp_done");
      step(2);
      check_fill(a0, r0, 32'h0000_0000, "t5a");
      check_fill(a0 + 8, r0 + 8, 32'h0000_0020, "t5b");

      // 6: write request is never accepted
      a0 = n_ack; k0 = n_rack;
      req_request = 1'b1; req_rnw = 1'b0; req_addr = 32'h6000_0000;
      step(10);
      check("t6_no_ack", n_rack - k0, 32'd0);
      check("t6_no_mem", n_ack - a0, 32'd0);
      check("t6_idle", {31'd0, busy}, 32'd0);
      req_request = 1'b0; req_rnw = 1'b1;
      step(2);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
